symbol_counter: RTL and testbench

//  Front stage of the Huffman encoder; feeds Sorting.

---
 rtl/symbol_counter_pkg.sv | 28 ++
 rtl/symbol_counter_sym_sat_cnt.sv | 32 +++
 rtl/symbol_counter.sv | 170 +++++++++++++++++
 tb/tb_symbol_counter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/symbol_counter_pkg.sv
// Shared definitions for the Huffman encoder front end (symbol counter),
// also consumed by the sorting and code-table stages.
//   SC_NUM_SYM    number of legal gray symbols (values 1..SC_NUM_SYM)
//   SC_PORT_SYM   number of per-symbol output ports on the block
//   SC_CW         count width
//   SC_SYM_IDX_W  width of a 0-based symbol index
//   SC_CNT_MAX    saturation value (counts are signed downstream)
//   sc_state_e    COUNT / PACK / DONE state encoding
package symbol_counter_pkg;

    localparam int SC_NUM_SYM   = 6;
    localparam int SC_PORT_SYM  = 6;
    localparam int SC_CW        = 8;
    localparam int SC_SYM_IDX_W = 3;
    localparam int SC_CNT_MAX   = 127;

    typedef enum logic [1:0] {
        ST_COUNT = 2'd0,
        ST_PACK  = 2'd1,
        ST_DONE  = 2'd2
    } sc_state_e;

    // True when d is a countable symbol, i.e. 1..n.
    function automatic logic sym_legal(input logic [7:0] d, input int n);
        return (d >= 8'd1) && (int'(d) <= n);
    endfunction

endpackage

// File: rtl/symbol_counter_sym_sat_cnt.sv
// sym_sat_cnt: CW-bit up counter with enable that sticks at MAX.
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-high clear
//   inc_en  increment request for this cycle
//   cnt     current count
module sym_sat_cnt #(
    parameter int CW  = 8,
    parameter int MAX = 127
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc_en,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_en && (cnt_q != CW'(MAX)))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/symbol_counter.sv
// symbol_counter: counts gray symbols 1..NUM_SYM over a frame of SAMPLES
// valid inputs, then spends NUM_SYM cycles compacting the non-zero counts
// (ascending symbol order) into O1..O6 / M1..M6 and raises CNT_valid.
// Ports:
//   clk, reset          clock, async active-high reset
//   gray_valid/data     input sample stream (accepted only while counting)
//   CNT1..CNT6          live raw per-symbol counts (saturating)
//   O1..O6, M1..M6      compacted counts and their 0-based symbol indices
//   num                 number of occupied O slots
//   CNT_valid           results final; held until reset
//   err                 sticky: an illegal symbol was accepted this frame
module symbol_counter
    import symbol_counter_pkg::*;
#(
    parameter int NUM_SYM = SC_NUM_SYM,
    parameter int SAMPLES = 100,
    parameter int CW      = SC_CW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    gray_valid,
    input  logic [7:0]              gray_data,
    output logic [CW-1:0]           CNT1,
    output logic [CW-1:0]           CNT2,
    output logic [CW-1:0]           CNT3,
    output logic [CW-1:0]           CNT4,
    output logic [CW-1:0]           CNT5,
    output logic [CW-1:0]           CNT6,
    output logic [CW-1:0]           O1,
    output logic [CW-1:0]           O2,
    output logic [CW-1:0]           O3,
    output logic [CW-1:0]           O4,
    output logic [CW-1:0]           O5,
    output logic [CW-1:0]           O6,
    output logic [SC_SYM_IDX_W-1:0] M1,
    output logic [SC_SYM_IDX_W-1:0] M2,
    output logic [SC_SYM_IDX_W-1:0] M3,
    output logic [SC_SYM_IDX_W-1:0] M4,
    output logic [SC_SYM_IDX_W-1:0] M5,
    output logic [SC_SYM_IDX_W-1:0] M6,
    output logic [SC_SYM_IDX_W-1:0] num,
    output logic                    CNT_valid,
    output logic                    err
);

    localparam int SCNT_W  = $clog2(SAMPLES + 1);
    localparam int CNT_MAX = (1 << (CW - 1)) - 1;
    localparam int IW      = SC_SYM_IDX_W;

    sc_state_e             state_q, state_d;
    logic [SCNT_W-1:0]     sample_cnt_q, sample_cnt_d;
    logic [IW-1:0]         pack_idx_q, pack_idx_d;
    logic [IW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         o_q [SC_PORT_SYM];
    logic [CW-1:0]         o_d [SC_PORT_SYM];
    logic [IW-1:0]         m_q [SC_PORT_SYM];
    logic [IW-1:0]         m_d [SC_PORT_SYM];
    logic [IW-1:0]         num_q, num_d;
    logic                  cnt_valid_q, cnt_valid_d;
    logic                  err_q, err_d;

    logic [CW-1:0]          cnt [SC_PORT_SYM];
    logic [SC_PORT_SYM-1:0] inc_en;
    logic                   accept;
    logic                   hit;

    assign accept = (state_q == ST_COUNT) && gray_valid;

    // One saturating counter per symbol; counters beyond NUM_SYM never fire.
    for (genvar g = 0; g < SC_PORT_SYM; g++) begin : g_cnt
        assign inc_en[g] = accept && (g < NUM_SYM) && (gray_data == 8'(g + 1));
        sym_sat_cnt #(.CW(CW), .MAX(CNT_MAX)) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .inc_en (inc_en[g]),
            .cnt    (cnt[g])
        );
    end

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        pack_idx_d   = pack_idx_q;
        wr_ptr_d     = wr_ptr_q;
        o_d          = o_q;
        m_d          = m_q;
        num_d        = num_q;
        cnt_valid_d  = cnt_valid_q;
        err_d        = err_q;
        hit          = 1'b0;
        case (state_q)
            ST_COUNT: begin
                if (accept) begin
                    sample_cnt_d = sample_cnt_q + 1'b1;
                    if (!sym_legal(gray_data, NUM_SYM))
                        err_d = 1'b1;
                    if (sample_cnt_q == SCNT_W'(SAMPLES - 1))
                        state_d = ST_PACK;
                end
            end
            ST_PACK: begin
                // Counters are frozen here, so one symbol is examined per cycle.
                hit        = (cnt[pack_idx_q] != '0);
                pack_idx_d = pack_idx_q + 1'b1;
                if (hit) begin
                    o_d[wr_ptr_q] = cnt[pack_idx_q];
                    m_d[wr_ptr_q] = pack_idx_q;
                    wr_ptr_d      = wr_ptr_q + 1'b1;
                end
                // num must include a write happening on this same final edge.
                if (pack_idx_q == IW'(NUM_SYM - 1)) begin
                    num_d       = hit ? (wr_ptr_q + 1'b1) : wr_ptr_q;
                    cnt_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: ;
            default: state_d = ST_COUNT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_COUNT;
            sample_cnt_q <= '0;
            pack_idx_q   <= '0;
            wr_ptr_q     <= '0;
            for (int i = 0; i < SC_PORT_SYM; i++) begin
                o_q[i] <= '0;
                m_q[i] <= '0;
            end
            num_q       <= '0;
            cnt_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            pack_idx_q   <= pack_idx_d;
            wr_ptr_q     <= wr_ptr_d;
            o_q          <= o_d;
            m_q          <= m_d;
            num_q        <= num_d;
            cnt_valid_q  <= cnt_valid_d;
            err_q        <= err_d;
        end
    end

    assign CNT1 = cnt[0];
    assign CNT2 = cnt[1];
    assign CNT3 = cnt[2];
    assign CNT4 = cnt[3];
    assign CNT5 = cnt[4];
    assign CNT6 = cnt[5];
    assign O1   = o_q[0];
    assign O2   = o_q[1];
    assign O3   = o_q[2];
    assign O4   = o_q[3];
    assign O5   = o_q[4];
    assign O6   = o_q[5];
    assign M1   = m_q[0];
    assign M2   = m_q[1];
    assign M3   = m_q[2];
    assign M4   = m_q[3];
    assign M5   = m_q[4];
    assign M6   = m_q[5];
    assign num       = num_q;
    assign CNT_valid = cnt_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_symbol_counter.sv
// Self-checking bench for symbol_counter. Frames of symbols are built as
// queues, shuffled, streamed with optional idle gaps, and the results are
// compared with a reference computed directly from the symbol queue.
// A second instance with SAMPLES=200 covers count saturation.
module tb_symbol_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       va, vb;
    logic [7:0] data;

    logic [7:0] cnt_a [6], o_a [6], cnt_b [6], o_b [6];
    logic [2:0] m_a [6], m_b [6];
    logic [2:0] num_a, num_b;
    logic       cv_a, cv_b, err_a, err_b;

    always #5 clk = ~clk;

    symbol_counter #(.SAMPLES(100)) u_dut (
        .clk(clk), .reset(reset), .gray_valid(va), .gray_data(data),
        .CNT1(cnt_a[0]), .CNT2(cnt_a[1]), .CNT3(cnt_a[2]),
        .CNT4(cnt_a[3]), .CNT5(cnt_a[4]), .CNT6(cnt_a[5]),
        .O1(o_a[0]), .O2(o_a[1]), .O3(o_a[2]), .O4(o_a[3]), .O5(o_a[4]), .O6(o_a[5]),
        .M1(m_a[0]), .M2(m_a[1]), .M3(m_a[2]), .M4(m_a[3]), .M5(m_a[4]), .M6(m_a[5]),
        .num(num_a), .CNT_valid(cv_a), .err(err_a)
    );

    symbol_counter #(.SAMPLES(200)) u_dut200 (
        .clk(clk), .reset(reset), .gray_valid(vb), .gray_data(data),
        .CNT1(cnt_b[0]), .CNT2(cnt_b[1]), .CNT3(cnt_b[2]),
        .CNT4(cnt_b[3]), .CNT5(cnt_b[4]), .CNT6(cnt_b[5]),
        .O1(o_b[0]), .O2(o_b[1]), .O3(o_b[2]), .O4(o_b[3]), .O5(o_b[4]), .O6(o_b[5]),
        .M1(m_b[0]), .M2(m_b[1]), .M3(m_b[2]), .M4(m_b[3]), .M5(m_b[4]), .M6(m_b[5]),
        .num(num_b), .CNT_valid(cv_b), .err(err_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int syms[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_v(input bit use_b, input bit v);
        if (use_b) vb = v;
        else       va = v;
    endtask

    task automatic do_reset();
        va = 1'b0; vb = 1'b0; data = 8'd0;
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic build(input int c0, input int c1, input int c2,
                         input int c3, input int c4, input int c5);
        int c[6];
        c = '{c0, c1, c2, c3, c4, c5};
        syms.delete();
        for (int s = 0; s < 6; s++)
            for (int r = 0; r < c[s]; r++) syms.push_back(s + 1);
    endtask

    task automatic shuffle();
        for (int i = syms.size() - 1; i > 0; i--) begin
            int j, t;
            j = $urandom_range(0, i);
            t = syms[i]; syms[i] = syms[j]; syms[j] = t;
        end
    endtask

    // Streams syms, then measures edges from the last accepted sample to
    // CNT_valid. With tail set, junk keeps arriving during PACK/DONE.
    task automatic send(input bit use_b, input bit gaps, input bit tail);
        int lat;
        foreach (syms[i]) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                set_v(use_b, 1'b0);
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            data = 8'(syms[i]);
            set_v(use_b, 1'b1);
            @(negedge clk);
        end
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            if (tail) data = 8'($urandom_range(0, 9));
            else      set_v(use_b, 1'b0);
            @(negedge clk);
            if (lat < 0 && (use_b ? cv_b : cv_a)) lat = n;
        end
        set_v(use_b, 1'b0);
        chk(use_b ? "latency_b" : "latency_a", lat, 6);
    endtask

    // Reference: tally the queue, saturate, then list non-zero symbols in order.
    task automatic check_model(input bit use_b, input string tag);
        int c[6], eo[6], em[6], en;
        bit e;
        c = '{default: 0}; eo = '{default: 0}; em = '{default: 0};
        en = 0; e = 1'b0;
        foreach (syms[i]) begin
            if (syms[i] >= 1 && syms[i] <= 6) c[syms[i] - 1]++;
            else e = 1'b1;
        end
        for (int s = 0; s < 6; s++) begin
            if (c[s] > 127) c[s] = 127;
            if (c[s] != 0) begin
                eo[en] = c[s]; em[en] = s; en++;
            end
        end
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_cnt%0d", tag, i + 1), use_b ? cnt_b[i] : cnt_a[i], c[i]);
            chk($sformatf("%s_o%0d", tag, i + 1), use_b ? o_b[i] : o_a[i], eo[i]);
            chk($sformatf("%s_m%0d", tag, i + 1), use_b ? m_b[i] : m_a[i], em[i]);
        end
        chk({tag, "_num"}, use_b ? num_b : num_a, en);
        chk({tag, "_valid"}, use_b ? cv_b : cv_a, 1);
        chk({tag, "_err"}, use_b ? err_b : err_a, e);
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_cnt%0d", tag, i + 1), cnt_a[i], 0);
            chk($sformatf("%s_o%0d", tag, i + 1), o_a[i], 0);
            chk($sformatf("%s_m%0d", tag, i + 1), m_a[i], 0);
        end
        chk({tag, "_num"}, num_a, 0);
        chk({tag, "_valid"}, cv_a, 0);
        chk({tag, "_err"}, err_a, 0);
    endtask

    // Drives the first n queued samples back to back on the 100-sample DUT.
    task automatic drive_n(input int n);
        for (int i = 0; i < n; i++) begin
            data = 8'(syms[i]); va = 1'b1;
            @(negedge clk);
        end
        va = 1'b0;
    endtask

    initial begin
        do_reset();
        check_zero("reset");
        chk("reset_b_valid", cv_b, 0);

        // 1) every symbol present, distinct counts
        build(40, 30, 15, 10, 4, 1); shuffle();
        send(1'b0, 1'b0, 1'b0);
        check_model(1'b0, "t1");

        // 2) two symbols only
        do_reset();
        build(0, 60, 0, 0, 40, 0); shuffle();
        send(1'b0, 1'b0, 1'b0);
        check_model(1'b0, "t2");

        // 3) gaps plus three illegal values counted as samples only
        do_reset();
        syms.delete();
        for (int i = 0; i < 97; i++) syms.push_back($urandom_range(1, 6));
        syms.insert($urandom_range(0, syms.size()), 0);
        syms.insert($urandom_range(0, syms.size()), 9);
        syms.insert($urandom_range(0, syms.size()), 255);
        send(1'b0, 1'b1, 1'b0);
        check_model(1'b0, "t3");
        chk("t3_sum", 32'(cnt_a[0]) + cnt_a[1] + cnt_a[2] + cnt_a[3] + cnt_a[4] + cnt_a[5], 97);

        // 4) single symbol, junk during PACK/DONE, then a whole repeated frame
        do_reset();
        build(0, 0, 100, 0, 0, 0);
        send(1'b0, 1'b0, 1'b1);
        check_model(1'b0, "t4");
        drive_n(100);
        repeat (3) @(negedge clk);
        check_model(1'b0, "t4_rep");

        // 5a) reset mid-frame, then a clean frame
        do_reset();
        build(40, 30, 15, 10, 4, 1); shuffle();
        drive_n(50);
        #2 reset = 1'b1;
        #1 check_zero("t5_mid");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        shuffle();
        send(1'b0, 1'b1, 1'b0);
        check_model(1'b0, "t5");

        // 5b) reset while packing
        do_reset();
        build(40, 30, 15, 10, 4, 1); shuffle();
        drive_n(100);
        @(negedge clk); @(negedge clk);
        #2 reset = 1'b1;
        #1 check_zero("t5_pack");
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_pack_valid_after", cv_a, 0);
        chk("t5_pack_num_after", num_a, 0);
        chk("t5_pack_o1_after", o_a[0], 0);

        // 6) 200-sample frame saturating one counter
        do_reset();
        build(200, 0, 0, 0, 0, 0);
        send(1'b1, 1'b0, 1'b0);
        check_model(1'b1, "t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule
